// File: rtl/prv_trap_pkg.sv
// prv_trap_pkg
// Shared types and helpers for the privileged trap sequencer:
//   trap_state_t - sequencer FSM states
//   trap_cause_t - captured trap identity (interrupt flag + cause code)
//   cause_width  - width of the externally visible cause field
// The optional WFI/SLEEP behaviour is enabled by defining PRV_TRAP_WFI_EN;
// the SLEEP encoding exists in every build so the state type is stable.
package prv_trap_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        INSERT = 3'd2,
        RET    = 3'd3,
        SLEEP  = 3'd4
    } trap_state_t;

    // Internal code field is fixed-width; the visible cause port is the low
    // cause_width() bits of it, so cause_width() must not exceed this.
    localparam int TRAP_CODE_W = 8;

    typedef struct packed {
        logic                   intr;
        logic [TRAP_CODE_W-1:0] code;
    } trap_cause_t;

    // $clog2 of the larger source count, never narrower than one bit.
    function automatic int cause_width(input int num_exc, input int num_int);
        int m;
        m = (num_exc > num_int) ? num_exc : num_int;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/prv_prio_enc.sv
// prv_prio_enc
// Lowest-index-wins priority encoder.
// Ports:
//   req   in  WIDTH  request vector
//   valid out 1      any request set
//   index out IDX_W  index of the lowest set request (0 when none)
module prv_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the last hit, the lowest index, sticks.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer
// Collects exception requests and interrupt lines, selects one trap
// (exceptions before interrupts, lowest index first inside each class),
// waits for the hazard unit to report a drained pipeline and then issues a
// single-cycle PC redirect together with the CSR-file latch strobe. Also
// sequences the mret redirect back to xepc.
//
// Optional build macro: PRV_TRAP_WFI_EN adds the wfi input and SLEEP state.
//
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset
//   exc_valid     exception requests (index = cause code)
//   int_raw       raw interrupt lines, synchronous to CLK
//   int_enable    per-line interrupt enable
//   global_ie     global interrupt enable
//   pipe_clear    pipeline drained indication
//   epc_in        faulting/interrupted PC
//   badaddr_in    faulting address
//   mret          trap return request
//   xtvec         trap vector base; [1:0]=mode, 1 = vectored
//   xepc_r        return address used by mret
//   wfi           wait-for-interrupt request (PRV_TRAP_WFI_EN only)
//   insert_pc     one-cycle redirect strobe
//   priv_pc       redirect target, valid with insert_pc
//   intr          captured trap is an interrupt
//   trap_take     one-cycle CSR latch strobe
//   cause         captured cause code
//   trap_epc      captured epc
//   trap_badaddr  captured badaddr (0 for interrupts)
//   busy          sequencer not idle
//   wfi_stall     stall while sleeping (0 without PRV_TRAP_WFI_EN)
module prv_trap_sequencer
    import prv_trap_pkg::*;
#(
    parameter int                 NUM_EXC       = 16,
    parameter int                 NUM_INT       = 12,
    parameter int                 WORD_W        = 32,
    parameter logic [NUM_INT-1:0] INT_EDGE_MASK = '0
) (
    input  logic                                   CLK,
    input  logic                                   nRST,
    input  logic [NUM_EXC-1:0]                     exc_valid,
    input  logic [NUM_INT-1:0]                     int_raw,
    input  logic [NUM_INT-1:0]                     int_enable,
    input  logic                                   global_ie,
    input  logic                                   pipe_clear,
    input  logic [WORD_W-1:0]                      epc_in,
    input  logic [WORD_W-1:0]                      badaddr_in,
    input  logic                                   mret,
    input  logic [WORD_W-1:0]                      xtvec,
    input  logic [WORD_W-1:0]                      xepc_r,
`ifdef PRV_TRAP_WFI_EN
    input  logic                                   wfi,
`endif
    output logic                                   insert_pc,
    output logic [WORD_W-1:0]                      priv_pc,
    output logic                                   intr,
    output logic                                   trap_take,
    output logic [cause_width(NUM_EXC,NUM_INT)-1:0] cause,
    output logic [WORD_W-1:0]                      trap_epc,
    output logic [WORD_W-1:0]                      trap_badaddr,
    output logic                                   busy,
    output logic                                   wfi_stall
);

    localparam int CAUSE_W   = cause_width(NUM_EXC, NUM_INT);
    localparam int EXC_IDX_W = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
    localparam int INT_IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    trap_state_t state_reg, state_next;

    trap_cause_t       cap_reg;
    logic [WORD_W-1:0] epc_reg;
    logic [WORD_W-1:0] badaddr_reg;

    logic [NUM_INT-1:0] pending_reg, pending_next;
    logic [NUM_INT-1:0] int_eligible;
    logic               int_wake;

    logic                 exc_any, int_any;
    logic [EXC_IDX_W-1:0] exc_idx;
    logic [INT_IDX_W-1:0] int_idx;
    trap_cause_t          exc_sel, int_sel;

    logic              load;
    trap_cause_t       load_val;
    logic [WORD_W-1:0] vec_pc;

    // ------------------------------------------------------------------
    // Interrupt pending bits
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_pend
        if (INT_EDGE_MASK[gi]) begin : g_edge
            logic int_prev_reg;
            logic int_taken;

            // Clear only when this very interrupt is handed to the CSR file.
            assign int_taken = (state_reg == INSERT) && cap_reg.intr &&
                               (cap_reg.code == TRAP_CODE_W'(gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    int_prev_reg <= 1'b0;
                end else begin
                    int_prev_reg <= int_raw[gi];
                end
            end

            // A fresh rising edge wins over a simultaneous clear so it is
            // never lost.
            assign pending_next[gi] = (int_raw[gi] & ~int_prev_reg) |
                                      (pending_reg[gi] & ~int_taken);
        end else begin : g_level
            assign pending_next[gi] = int_raw[gi];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign int_eligible = pending_reg & int_enable & {NUM_INT{global_ie}};
    // Wake-up from SLEEP deliberately ignores global_ie.
    assign int_wake     = |(pending_reg & int_enable);

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
    prv_prio_enc #(
        .WIDTH (NUM_EXC),
        .IDX_W (EXC_IDX_W)
    ) u_exc_enc (
        .req   (exc_valid),
        .valid (exc_any),
        .index (exc_idx)
    );

    prv_prio_enc #(
        .WIDTH (NUM_INT),
        .IDX_W (INT_IDX_W)
    ) u_int_enc (
        .req   (int_eligible),
        .valid (int_any),
        .index (int_idx)
    );

    assign exc_sel.intr = 1'b0;
    assign exc_sel.code = TRAP_CODE_W'(exc_idx);
    assign int_sel.intr = 1'b1;
    assign int_sel.code = TRAP_CODE_W'(int_idx);

    // Vectored mode adds 4*cause for interrupts only; wraps naturally.
    always_comb begin
        vec_pc = {xtvec[WORD_W-1:2], 2'b00};
        if ((xtvec[1:0] == 2'b01) && cap_reg.intr) begin
            vec_pc = vec_pc + (WORD_W'(cap_reg.code) << 2);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        load_val   = exc_sel;
        insert_pc  = 1'b0;
        trap_take  = 1'b0;
        priv_pc    = '0;

        case (state_reg)
            IDLE: begin
                if (exc_any) begin
                    state_next = DRAIN;
                    load       = 1'b1;
                    load_val   = exc_sel;
                end else if (int_any) begin
                    state_next = DRAIN;
                    load       = 1'b1;
                    load_val   = int_sel;
                end else if (mret) begin
                    state_next = RET;
`ifdef PRV_TRAP_WFI_EN
                // Not sleeping while a wake source is already present keeps
                // a held wfi from bouncing between IDLE and SLEEP.
                end else if (wfi && !int_wake) begin
                    state_next = SLEEP;
`endif
                end
            end

            // Captured trap is frozen here; new requests wait for IDLE.
            DRAIN: begin
                if (pipe_clear) begin
                    state_next = INSERT;
                end
            end

            INSERT: begin
                insert_pc  = 1'b1;
                trap_take  = 1'b1;
                priv_pc    = vec_pc;
                state_next = IDLE;
            end

            RET: begin
                insert_pc  = 1'b1;
                priv_pc    = xepc_r;
                state_next = IDLE;
            end

            SLEEP: begin
`ifdef PRV_TRAP_WFI_EN
                if (exc_any) begin
                    state_next = DRAIN;
                    load       = 1'b1;
                    load_val   = exc_sel;
                end else if (int_wake) begin
                    if (global_ie) begin
                        state_next = DRAIN;
                        load       = 1'b1;
                        load_val   = int_sel;
                    end else begin
                        state_next = IDLE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end

            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Captured trap registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cap_reg     <= '0;
            epc_reg     <= '0;
            badaddr_reg <= '0;
        end else if (load) begin
            cap_reg     <= load_val;
            epc_reg     <= epc_in;
            badaddr_reg <= load_val.intr ? '0 : badaddr_in;
        end
    end

    assign intr         = cap_reg.intr;
    assign cause        = cap_reg.code[CAUSE_W-1:0];
    assign trap_epc     = epc_reg;
    assign trap_badaddr = badaddr_reg;
    assign busy         = (state_reg != IDLE);

`ifdef PRV_TRAP_WFI_EN
    assign wfi_stall = (state_reg == SLEEP);
`else
    assign wfi_stall = 1'b0;
`endif

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// tb_prv_trap_sequencer
// Directed-vector bench for prv_trap_sequencer. Line 3 is built as an
// edge-latched interrupt, every other line is level. Inputs change and
// outputs are observed 1 time unit after the rising clock edge.
module tb_prv_trap_sequencer;

    localparam int NUM_EXC = 16;
    localparam int NUM_INT = 12;
    localparam int WORD_W  = 32;
    localparam int CAUSE_W = 4;

    logic                CLK;
    logic                nRST;
    logic [NUM_EXC-1:0]  exc_valid;
    logic [NUM_INT-1:0]  int_raw;
    logic [NUM_INT-1:0]  int_enable;
    logic                global_ie;
    logic                pipe_clear;
    logic [WORD_W-1:0]   epc_in;
    logic [WORD_W-1:0]   badaddr_in;
    logic                mret;
    logic [WORD_W-1:0]   xtvec;
    logic [WORD_W-1:0]   xepc_r;
`ifdef PRV_TRAP_WFI_EN
    logic                wfi;
`endif
    logic                insert_pc;
    logic [WORD_W-1:0]   priv_pc;
    logic                intr;
    logic                trap_take;
    logic [CAUSE_W-1:0]  cause;
    logic [WORD_W-1:0]   trap_epc;
    logic [WORD_W-1:0]   trap_badaddr;
    logic                busy;
    logic                wfi_stall;

    int n_checks = 0;
    int n_fail   = 0;

    prv_trap_sequencer #(
        .NUM_EXC       (NUM_EXC),
        .NUM_INT       (NUM_INT),
        .WORD_W        (WORD_W),
        .INT_EDGE_MASK (12'h008)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .exc_valid    (exc_valid),
        .int_raw      (int_raw),
        .int_enable   (int_enable),
        .global_ie    (global_ie),
        .pipe_clear   (pipe_clear),
        .epc_in       (epc_in),
        .badaddr_in   (badaddr_in),
        .mret         (mret),
        .xtvec        (xtvec),
        .xepc_r       (xepc_r),
`ifdef PRV_TRAP_WFI_EN
        .wfi          (wfi),
`endif
        .insert_pc    (insert_pc),
        .priv_pc      (priv_pc),
        .intr         (intr),
        .trap_take    (trap_take),
        .cause        (cause),
        .trap_epc     (trap_epc),
        .trap_badaddr (trap_badaddr),
        .busy         (busy),
        .wfi_stall    (wfi_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST       = 1'b0;
        exc_valid  = '0;
        int_raw    = '0;
        int_enable = '0;
        global_ie  = 1'b0;
        pipe_clear = 1'b0;
        epc_in     = '0;
        badaddr_in = '0;
        mret       = 1'b0;
        xtvec      = '0;
        xepc_r     = '0;
`ifdef PRV_TRAP_WFI_EN
        wfi        = 1'b0;
`endif

        // ---- reset state ----
        #3;
        check_eq("rst_insert_pc", insert_pc, 0);
        check_eq("rst_trap_take", trap_take, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cause", cause, 0);
        check_eq("rst_intr", intr, 0);
        check_eq("rst_epc", trap_epc, 0);
        check_eq("rst_badaddr", trap_badaddr, 0);
        check_eq("rst_priv_pc", priv_pc, 0);
        check_eq("rst_wfi_stall", wfi_stall, 0);
        $display("txn reset: outputs observed");
        @(negedge CLK);
        nRST = 1'b1;
        step();

        // ---- exception 0x0024, lowest index 2 wins, latency N+2 ----
        exc_valid  = 16'h0024;
        pipe_clear = 1'b1;
        epc_in     = 32'h0000_0100;
        badaddr_in = 32'h0000_DEAD;
        xtvec      = 32'h8000_0001;
        step();
        exc_valid = '0;
        check_eq("exc_busy", busy, 1);
        check_eq("exc_cause", cause, 2);
        check_eq("exc_intr", intr, 0);
        check_eq("exc_epc", trap_epc, 32'h100);
        check_eq("exc_badaddr", trap_badaddr, 32'hDEAD);
        check_eq("exc_no_early_insert", insert_pc, 0);
        step();
        check_eq("exc_insert_pc", insert_pc, 1);
        check_eq("exc_trap_take", trap_take, 1);
        check_eq("exc_priv_pc", priv_pc, 32'h8000_0000);
        step();
        check_eq("exc_back_idle", busy, 0);
        check_eq("exc_strobe_one_cycle", insert_pc, 0);
        $display("txn exception 0x24: cause=%0d priv_pc checked", cause);

        // ---- level interrupt 7, vectored ----
        int_enable = 12'h080;
        global_ie  = 1'b1;
        int_raw    = 12'h080;
        step();
        check_eq("int7_latency_idle", busy, 0);
        step();
        int_raw = '0;
        check_eq("int7_cause", cause, 7);
        check_eq("int7_intr", intr, 1);
        check_eq("int7_badaddr_zero", trap_badaddr, 0);
        step();
        check_eq("int7_insert_pc", insert_pc, 1);
        check_eq("int7_priv_pc", priv_pc, 32'h8000_001C);
        step();
        step();
        check_eq("int7_no_retrigger", busy, 0);
        $display("txn level int 7: priv_pc vectored");

        // ---- two level interrupts, lowest index 6 wins ----
        int_enable = 12'h440;
        int_raw    = 12'h440;
        step();
        step();
        int_raw = '0;
        check_eq("int6_cause", cause, 6);
        step();
        check_eq("int6_priv_pc", priv_pc, 32'h8000_0018);
        step();
        step();
        check_eq("int6_idle", busy, 0);
        $display("txn int 6 vs 10: lowest index");

        // ---- exception beats simultaneous eligible interrupt ----
        global_ie  = 1'b0;
        int_enable = 12'h001;
        int_raw    = 12'h001;
        step();
        check_eq("prio_masked_idle", busy, 0);
        global_ie = 1'b1;
        exc_valid = 16'h8000;
        int_raw   = '0;
        epc_in    = 32'h0000_0140;
        step();
        exc_valid = '0;
        global_ie = 1'b0;
        check_eq("prio_cause", cause, 15);
        check_eq("prio_intr", intr, 0);
        step();
        check_eq("prio_priv_pc", priv_pc, 32'h8000_0000);
        step();
        $display("txn exc 15 vs int 0: exception wins");

        // ---- edge line 3 pulsed while masked, taken later, then cleared ----
        xtvec      = 32'h0000_2000;
        int_enable = 12'h008;
        int_raw    = 12'h008;
        step();
        int_raw = '0;
        step();
        step();
        check_eq("edge3_masked_idle", busy, 0);
        global_ie = 1'b1;
        step();
        check_eq("edge3_cause", cause, 3);
        check_eq("edge3_intr", intr, 1);
        step();
        check_eq("edge3_trap_take", trap_take, 1);
        check_eq("edge3_priv_pc", priv_pc, 32'h0000_2000);
        step();
        step();
        check_eq("edge3_pending_cleared", busy, 0);
        global_ie  = 1'b0;
        int_enable = '0;
        $display("txn edge int 3: taken once");

        // ---- exception and mret together: exception wins ----
        xepc_r    = 32'h5555_0000;
        exc_valid = 16'h0010;
        mret      = 1'b1;
        step();
        exc_valid = '0;
        mret      = 1'b0;
        check_eq("excmret_cause", cause, 4);
        step();
        check_eq("excmret_priv_pc", priv_pc, 32'h0000_2000);
        check_eq("excmret_take", trap_take, 1);
        step();
        check_eq("excmret_no_ret", insert_pc, 0);
        $display("txn exc 4 + mret: trap taken");

        // ---- mret alone ----
        mret = 1'b1;
        step();
        mret = 1'b0;
        check_eq("ret_insert_pc", insert_pc, 1);
        check_eq("ret_trap_take", trap_take, 0);
        check_eq("ret_priv_pc", priv_pc, 32'h5555_0000);
        step();
        check_eq("ret_idle", busy, 0);
        $display("txn mret: redirect to xepc");

        // ---- DRAIN holds without pipe_clear, ignores second exception ----
        pipe_clear = 1'b0;
        exc_valid  = 16'h0200;
        epc_in     = 32'h0000_0200;
        badaddr_in = 32'h0000_00B0;
        step();
        exc_valid = '0;
        step();
        exc_valid = 16'h0002;
        epc_in    = 32'h0000_0300;
        step();
        exc_valid = '0;
        check_eq("drain_cause_kept", cause, 9);
        check_eq("drain_epc_kept", trap_epc, 32'h200);
        step();
        step();
        check_eq("drain_holding", busy, 1);
        check_eq("drain_no_insert", insert_pc, 0);
        pipe_clear = 1'b1;
        step();
        check_eq("drain_insert", insert_pc, 1);
        check_eq("drain_insert_cause", cause, 9);
        check_eq("drain_badaddr", trap_badaddr, 32'hB0);
        step();
        $display("txn drain hold: cause 9 kept");

        // ---- async reset mid-DRAIN ----
        pipe_clear = 1'b0;
        exc_valid  = 16'h0002;
        step();
        exc_valid = '0;
        check_eq("arst_in_drain", busy, 1);
        nRST = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_cause", cause, 0);
        check_eq("arst_insert", insert_pc, 0);
        @(negedge CLK);
        nRST = 1'b1;
        pipe_clear = 1'b1;
        step();
        check_eq("arst_stays_idle", busy, 0);
        $display("txn async reset in drain");

`ifdef PRV_TRAP_WFI_EN
        // ---- WFI wake with global_ie=0 returns to IDLE, no trap ----
        int_enable = 12'h800;
        global_ie  = 1'b0;
        wfi        = 1'b1;
        step();
        wfi = 1'b0;
        check_eq("wfi_stall_on", wfi_stall, 1);
        step();
        check_eq("wfi_still_sleep", wfi_stall, 1);
        int_raw = 12'h800;
        step();
        check_eq("wfi_pend_latency", wfi_stall, 1);
        step();
        int_raw = '0;
        check_eq("wfi_stall_off", wfi_stall, 0);
        check_eq("wfi_idle", busy, 0);
        step();
        check_eq("wfi_no_trap", insert_pc, 0);
        check_eq("wfi_no_trap_busy", busy, 0);
        $display("txn wfi wake without trap");
`else
        check_eq("wfi_stall_tied", wfi_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prv_trap_sequencer.md
Name: prv_trap_sequencer

Overview:
Parametrised successor to the fixed priv-to-pipeline trap signalling. Collects NUM_EXC exception sources and NUM_INT interrupt lines with per-line edge/level latching, priority-selects one trap, and handshakes with the hazard unit. It waits for the pipeline to drain before issuing a one-cycle PC redirect. It sits between the hazard unit and the CSR file inside the priv block.

Parameters:
NUM_EXC, 16, number of synchronous exception sources; index equals cause code.
NUM_INT, 12, number of interrupt lines; index equals interrupt cause code.
WORD_W, 32, PC/address width.
INT_EDGE_MASK, '0 (NUM_INT bits), bit=1 makes that line edge-latched; bit=0 makes it level.

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
exc_valid  in  NUM_EXC  exception requests from hazard unit (one-hot or multi)
int_raw  in  NUM_INT  raw interrupt lines (synchronous to CLK)
int_enable  in  NUM_INT  mie-style enable mask
global_ie  in  1  mstatus interrupt enable
pipe_clear  in  1  pipeline drained, from hazard unit
epc_in  in  WORD_W  faulting/interrupted PC
badaddr_in  in  WORD_W  faulting address
mret  in  1  return request
xtvec  in  WORD_W  trap vector; bits[1:0]=mode (1=vectored)
xepc_r  in  WORD_W  current epc for mret
insert_pc  out  1  one-cycle redirect strobe
priv_pc  out  WORD_W  redirect target, valid with insert_pc
intr  out  1  captured trap is an interrupt
trap_take  out  1  one-cycle strobe to CSR file: latch cause/epc/badaddr
cause  out  CAUSE_W  captured cause code
trap_epc  out  WORD_W  captured epc
trap_badaddr  out  WORD_W  captured badaddr (0 for interrupts)
busy  out  1  high in any state other than IDLE
wfi_stall  out  1  stall request (PRV_TRAP_WFI_EN only; tied 0 otherwise)

Behaviour:
- Reset: state=IDLE, pending=0; every output 0.
- Pending: edge lines set on a 0->1 transition of int_raw and clear only on trap_take for that cause. Level lines mirror int_raw registered (1-cycle latency).
- Eligible interrupts = pending & int_enable, gated by global_ie.
- Priority: any exception beats any interrupt. Within a class, the lowest index wins; callers order their sources accordingly.
- IDLE:
  - exception or eligible interrupt -> DRAIN; cause/intr/epc/badaddr captured on this edge.
  - Otherwise mret -> RET.
  - Exception and mret in the same cycle: the exception wins.
- DRAIN:
  - Captured values are frozen; new exceptions are ignored, and new interrupts stay pending.
  - When pipe_clear=1 -> INSERT. Without pipe_clear, DRAIN holds indefinitely.
- INSERT (1 cycle):
  - insert_pc=1, trap_take=1.
  - priv_pc = {xtvec[WORD_W-1:2],2'b00}, plus 4*cause when mode=1 and intr=1; addition wraps modulo 2^WORD_W.
  - Edge-pending bit for a taken interrupt clears here.
  - Next state is IDLE; requests present this cycle are evaluated in IDLE next cycle.
- RET (1 cycle): insert_pc=1, priv_pc=xepc_r, trap_take=0 -> IDLE.
- Trap latency: exception in cycle N with pipe_clear already high -> insert_pc in cycle N+2.
- Async reset mid-DRAIN/INSERT returns to IDLE immediately with no strobe.
- CAUSE_W = $clog2(max(NUM_EXC,NUM_INT)); unused cause bits are 0.

Optional Feature:
PRV_TRAP_WFI_EN:
- Defined: adds input wfi and state SLEEP.
  - In IDLE, wfi with no eligible trap -> SLEEP; wfi_stall=1.
  - SLEEP exits when (pending & int_enable)!=0, ignoring global_ie.
  - On exit, global_ie=1 -> DRAIN; otherwise -> IDLE, where the pipeline resumes.
  - An exception in SLEEP -> DRAIN.
- Undefined: no wfi port; wfi_stall tied 0; WFI behaves as a NOP.

Decomposition:
- Package prv_trap_pkg: trap_state_t enum {IDLE,DRAIN,INSERT,RET,SLEEP}, CAUSE_W computation function, trap_cause_t struct {intr, code}.
- One sub-module, prv_prio_enc: parametrised lowest-index priority encoder (WIDTH in; valid + index out), instantiated once for exceptions and once for interrupts.

Test Plan:
- exc_valid=0x0024, pipe_clear=1 -> cause=2, intr=0, insert_pc 2 cycles later, priv_pc=xtvec&~3.
- int_raw[7] level, enabled, global_ie=1, xtvec=0x8000_0001 -> cause=7, intr=1, priv_pc=0x8000_001C.
- Edge line 3 pulsed 1 cycle while global_ie=0, then global_ie=1 -> trap cause 3 taken; pending[3]=0 after INSERT.
- exc_valid[4] and mret same cycle -> exception trap; no RET redirect.
- Exception with pipe_clear=0 for 5 cycles, second exception mid-DRAIN -> first cause kept; insert 1 cycle after pipe_clear.
- With PRV_TRAP_WFI_EN: wfi, then int_raw[11] enabled with global_ie=0 -> wfi_stall drops, no trap, state IDLE.
